// File: rtl/truth_sweep.sv
// Truth-table sweeper: walks {x,y,z} through 000..111, holds each vector SETTLE cycles, then captures s1/s2.
// Optional build macro SWEEP_CHECK_EN adds the EXP1/EXP2 comparison that drives ok.
module truth_sweep #(
    parameter int         SETTLE = 1,
    parameter logic [7:0] EXP1   = 8'h3F,
    parameter logic [7:0] EXP2   = 8'h30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       s1,
    input  logic       s2,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt1,
    output logic [7:0] tt2,
    output logic       ok
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] tt1_q, tt1_d;
    logic [7:0] tt2_q, tt2_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            tt1_q   <= 8'h00;
            tt2_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt1_q   <= tt1_d;
            tt2_q   <= tt2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt1_d   = tt1_q;
        tt2_d   = tt2_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = 3'd0;
                    cnt_d   = 4'd0;
                    tt1_d   = 8'h00;
                    tt2_d   = 8'h00;
                end
            end
            DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                // Captured unfiltered so X/Z from the function under test stays visible.
                tt1_d[idx_q] = s1;
                tt2_d[idx_q] = s2;
                if (idx_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = 4'd0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign {x, y, z} = busy ? idx_q : 3'b000;
    assign tt1       = tt1_q;
    assign tt2       = tt2_q;

`ifdef SWEEP_CHECK_EN
    logic ok_q, ok_d;

    // tt*_d already includes the bit captured in the final SAMPLE.
    always_comb begin
        ok_d = ok_q;
        if (state_q == IDLE && start) begin
            ok_d = 1'b0;
        end else if (state_q == SAMPLE && idx_q == 3'd7) begin
            ok_d = (tt1_d == EXP1) && (tt2_d == EXP2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ok_q <= 1'b0;
        end else begin
            ok_q <= ok_d;
        end
    end

    assign ok = ok_q;
`else
    assign ok = 1'b0;
`endif

endmodule

// File: tb/tb_truth_sweep.sv
// Directed bench for truth_sweep: three instances (SETTLE=1, SETTLE=3, SETTLE=1 with s2 stuck at 0).
module tb_truth_sweep;

`ifdef SWEEP_CHECK_EN
    localparam logic OK_EXP = 1'b1;
`else
    localparam logic OK_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: SETTLE=1, s1=~(x&y), s2=x&~y
    logic       rst_a, start_a, s1_a, s2_a, x_a, y_a, z_a, busy_a, done_a, ok_a;
    logic [7:0] tt1_a, tt2_a;
    assign s1_a = ~(x_a & y_a);
    assign s2_a = x_a & ~y_a;
    truth_sweep #(.SETTLE(1)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .s1(s1_a), .s2(s2_a),
        .x(x_a), .y(y_a), .z(z_a), .busy(busy_a), .done(done_a),
        .tt1(tt1_a), .tt2(tt2_a), .ok(ok_a));

    // Instance B: SETTLE=3, same function
    logic       rst_b, start_b, s1_b, s2_b, x_b, y_b, z_b, busy_b, done_b, ok_b;
    logic [7:0] tt1_b, tt2_b;
    assign s1_b = ~(x_b & y_b);
    assign s2_b = x_b & ~y_b;
    truth_sweep #(.SETTLE(3)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .s1(s1_b), .s2(s2_b),
        .x(x_b), .y(y_b), .z(z_b), .busy(busy_b), .done(done_b),
        .tt1(tt1_b), .tt2(tt2_b), .ok(ok_b));

    // Instance C: SETTLE=1, s2 stuck at 0
    logic       rst_c, start_c, s1_c, s2_c, x_c, y_c, z_c, busy_c, done_c, ok_c;
    logic [7:0] tt1_c, tt2_c;
    assign s1_c = ~(x_c & y_c);
    assign s2_c = 1'b0;
    truth_sweep #(.SETTLE(1)) dut_c (
        .clk(clk), .reset(rst_c), .start(start_c), .s1(s1_c), .s2(s2_c),
        .x(x_c), .y(y_c), .z(z_c), .busy(busy_c), .done(done_c),
        .tt1(tt1_c), .tt2(tt2_c), .ok(ok_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int n;
    int first_done, second_done;

    initial begin
        rst_a = 1'b1; start_a = 1'b0;
        rst_b = 1'b1; start_b = 1'b0;
        rst_c = 1'b1; start_c = 1'b0;
        tick();
        tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Reset state
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_xyz", 32'({x_a, y_a, z_a}), 32'd0);
        chk("rst_tt1", 32'(tt1_a), 32'h00);
        chk("rst_tt2", 32'(tt2_a), 32'h00);
        chk("rst_ok", 32'(ok_a), 32'd0);

        // Sweep A: exact 16-edge latency, vector stepping, held 2 cycles each
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("a_busy", 32'(busy_a), 32'd1);
            chk("a_xyz", 32'({x_a, y_a, z_a}), 32'(k / 2));
            chk("a_done_early", 32'(done_a), 32'd0);
            tick();
        end
        chk("a_done", 32'(done_a), 32'd1);
        chk("a_done_busy", 32'(busy_a), 32'd0);
        chk("a_done_xyz", 32'({x_a, y_a, z_a}), 32'd0);
        chk("a_tt1", 32'(tt1_a), 32'h3F);
        chk("a_tt2", 32'(tt2_a), 32'h30);
        chk("a_ok", 32'(ok_a), 32'(OK_EXP));
        tick();
        chk("a_done_pulse", 32'(done_a), 32'd0);
        chk("a_idle_busy", 32'(busy_a), 32'd0);
        tick();
        tick();
        chk("a_hold_tt1", 32'(tt1_a), 32'h3F);
        chk("a_hold_tt2", 32'(tt2_a), 32'h30);
        chk("a_hold_ok", 32'(ok_a), 32'(OK_EXP));

        // Sweep B: SETTLE=3 gives 32 edges
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done_b) begin
                n = k;
                break;
            end
        end
        chk("b_latency", 32'(n), 32'd32);
        chk("b_tt1", 32'(tt1_b), 32'h3F);
        chk("b_tt2", 32'(tt2_b), 32'h30);
        chk("b_ok", 32'(ok_b), 32'(OK_EXP));

        // Sweep C: s2 stuck at 0 must fail the check
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        for (int k = 0; k < 16; k++) tick();
        chk("c_done", 32'(done_c), 32'd1);
        chk("c_tt1", 32'(tt1_c), 32'h3F);
        chk("c_tt2", 32'(tt2_c), 32'h00);
        chk("c_ok", 32'(ok_c), 32'd0);

        // Reset and start together: reset wins
        tick();
        rst_a = 1'b1; start_a = 1'b1;
        tick();
        rst_a = 1'b0; start_a = 1'b0;
        chk("rs_busy", 32'(busy_a), 32'd0);
        chk("rs_tt1", 32'(tt1_a), 32'h00);
        chk("rs_ok", 32'(ok_a), 32'd0);

        // Reset on the 5th cycle of a sweep aborts with no done
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("ab_partial_tt1", 32'(tt1_a), 32'h03);
        chk("ab_busy_pre", 32'(busy_a), 32'd1);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk("ab_busy", 32'(busy_a), 32'd0);
        chk("ab_done", 32'(done_a), 32'd0);
        chk("ab_xyz", 32'({x_a, y_a, z_a}), 32'd0);
        chk("ab_tt1", 32'(tt1_a), 32'h00);
        chk("ab_tt2", 32'(tt2_a), 32'h00);
        chk("ab_ok", 32'(ok_a), 32'd0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done_a) n++;
        end
        chk("ab_no_done", 32'(n), 32'd0);

        // New sweep after abort completes normally
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (done_a) begin
                n = k;
                break;
            end
        end
        chk("re_latency", 32'(n), 32'd16);
        chk("re_tt1", 32'(tt1_a), 32'h3F);
        chk("re_tt2", 32'(tt2_a), 32'h30);
        tick();

        // Start held high for 40 cycles: back-to-back sweeps, done every 18 cycles
        first_done = 0;
        second_done = 0;
        start_a = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done_a) begin
                if (first_done == 0) first_done = c;
                else if (second_done == 0) second_done = c;
            end
            if (c == 2) chk("bb_busy_mid", 32'(busy_a), 32'd1);
            if (c == 18) chk("bb_idle_gap", 32'(busy_a), 32'd0);
            if (c == 19) chk("bb_relaunch", 32'({busy_a, x_a, y_a, z_a}), 32'h8);
        end
        start_a = 1'b0;
        chk("bb_first", 32'(first_done), 32'd17);
        chk("bb_spacing", 32'(second_done - first_done), 32'd18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/truth_sweep.md
TRUTH_SWEEP -- requirements
Module: truth_sweep

Interface
REQ-001 The module SHALL have parameter SETTLE, default 1, giving the cycles each input vector is held before sampling (legal range 1..15).
REQ-002 The module SHALL have parameter EXP1, default 8'h3F, giving the expected s1 truth table (used only under SWEEP_CHECK_EN).
REQ-003 The module SHALL have parameter EXP2, default 8'h30, giving the expected s2 truth table (used only under SWEEP_CHECK_EN).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port start, input, 1 bit: request one full sweep.
REQ-007 The module SHALL have ports s1 and s2, input, 1 bit each: outputs of the downstream combinational function under test.
REQ-008 The module SHALL have ports x, y and z, output, 1 bit each: the stimulus vector driven to the function under test.
REQ-009 The module SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle pulse marking sweep completion.
REQ-011 The module SHALL have ports tt1 and tt2, output, 8 bits each: captured truth tables for s1 and s2, where bit i holds the value for vector i.
REQ-012 The module SHALL have port ok, output, 1 bit: the result of the truth-table check.

Function
REQ-013 The FSM SHALL have the states IDLE, DRIVE, SAMPLE and DONE; a 3-bit index idx SHALL select the vector, with {x,y,z} = idx (x = MSB).
REQ-014 In IDLE with start=1, the FSM SHALL go to DRIVE on the next edge with idx=0 and the settle counter=0, and SHALL clear tt1 and tt2 to 0.
REQ-015 In DRIVE, the FSM SHALL hold {x,y,z}=idx for exactly SETTLE cycles, then go to SAMPLE.
REQ-016 In SAMPLE, the FSM SHALL keep {x,y,z} unchanged and, on the edge leaving SAMPLE, write tt1[idx]<=s1 and tt2[idx]<=s2.
REQ-017 From SAMPLE, if idx!=7 the FSM SHALL go to DRIVE with idx+1 and the settle counter cleared; if idx==7 it SHALL go to DONE (no wrap to 0 within a sweep).
REQ-018 In DONE, the module SHALL assert done=1 for exactly one cycle and the FSM SHALL then return to IDLE unconditionally.
REQ-019 Sweep latency SHALL be exactly 8*(SETTLE+1) edges from the start-sampling edge to the edge entering DONE; the default gives 16.
REQ-020 busy SHALL be 1 in DRIVE and SAMPLE and 0 in IDLE and DONE.
REQ-021 {x,y,z} SHALL be 3'b000 in IDLE and DONE.
REQ-022 start SHALL be ignored in DRIVE, SAMPLE and DONE; start held high continuously SHALL launch a new sweep from each IDLE visit, giving back-to-back sweeps with one IDLE cycle between them.
REQ-023 tt1 and tt2 SHALL hold their values from DONE until the next accepted start.
REQ-024 If s1 or s2 is X/Z when sampled, the module SHALL capture it as-is, with no filtering.

Reset
REQ-025 When reset=1 at an edge, the module SHALL force state=IDLE, idx=0, settle counter=0, x=y=z=0, busy=0, done=0, tt1=tt2=8'h00 and ok=0.
REQ-026 When reset and start are both high at the same edge, reset SHALL win.
REQ-027 A reset during a sweep SHALL abort it with no done pulse, and partial tables SHALL NOT be retained.

Configuration
REQ-028 With macro SWEEP_CHECK_EN defined, ok SHALL be set on the edge entering DONE to (tt1_final==EXP1 && tt2_final==EXP2), including the bit captured in the final SAMPLE, and SHALL be held until the next accepted start or reset.
REQ-029 With SWEEP_CHECK_EN defined, ok SHALL clear to 0 when a start is accepted.
REQ-030 Without SWEEP_CHECK_EN, ok SHALL be tied to 0, no comparison logic SHALL exist, and EXP1/EXP2 SHALL be unused.

Verification
REQ-031 With s1=~(x&y) and s2=x&~y attached, SETTLE=1 and a start pulse, the bench SHALL see done after 16 edges, tt1=8'h3F, tt2=8'h30, and ok=1 (macro on) or 0 (macro off).
REQ-032 With the same DUT, the bench SHALL see {x,y,z} step 000..111 and each value held exactly SETTLE+1=2 cycles while busy=1.
REQ-033 With SETTLE=3, the bench SHALL see done exactly 32 edges after start and the same tables as REQ-031.
REQ-034 With s2 stuck at 0 and the macro on, the bench SHALL see tt2=8'h00 and ok=0 at done.
REQ-035 With reset asserted on the 5th cycle of a sweep, the bench SHALL see the outputs at their reset values next cycle and no done pulse, and a new start SHALL then complete normally.
REQ-036 With start held high for 40 cycles, the bench SHALL see done pulses spaced 18 cycles apart and start ignored while busy.
